// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter for four requesters sharing one 2-bit channel.
// The owner keeps the grant for at most HOLD_MAX cycles, then priority rotates past it.
module rr_mux_arbiter #(
  parameter int HOLD_MAX = 4  // legal range 1..15
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [3:0] req,
  input  logic [1:0] p0,
  input  logic [1:0] p1,
  input  logic [1:0] p2,
  input  logic [1:0] p3,
  output logic [3:0] grant,
  output logic [1:0] sel,
  output logic [1:0] sout,
  output logic       sout_vld,
  output logic       o_dbg_state
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } state_t;

  state_t     r_state;
  logic [3:0] r_grant;
  logic [1:0] r_sel;
  logic [1:0] r_ptr;
  logic [3:0] r_hcnt;

  logic       w_found;
  logic [1:0] w_win;
  logic       w_release;
  logic [1:0] w_mux;

  // Search starts just after the last owner and wraps, so the last owner is tried last.
  always_comb begin
    logic [1:0] v_idx;
    w_found = 1'b0;
    w_win   = r_ptr;
    v_idx   = r_ptr;
    for (int k = 1; k <= 4; k++) begin
      v_idx = r_ptr + 2'(k);
      if (!w_found && req[v_idx]) begin
        w_found = 1'b1;
        w_win   = v_idx;
      end
    end
  end

  assign w_release = (req[r_sel] == 1'b0) || (r_hcnt == 4'(HOLD_MAX));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= ST_IDLE;
      r_grant <= 4'b0000;
      r_sel   <= 2'b00;
      r_ptr   <= 2'b11;
      r_hcnt  <= 4'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_state <= ST_OWN;
            r_grant <= 4'b0001 << w_win;
            r_sel   <= w_win;
            r_ptr   <= w_win;
            r_hcnt  <= 4'd1;
          end
        end
        ST_OWN: begin
          if (!w_release) begin
            r_hcnt <= r_hcnt + 4'd1;
          end else if (w_found) begin
            // Handover at the release edge; a lone requester is simply re-granted.
            r_grant <= 4'b0001 << w_win;
            r_sel   <= w_win;
            r_ptr   <= w_win;
            r_hcnt  <= 4'd1;
          end else begin
            r_state <= ST_IDLE;
            r_grant <= 4'b0000;
            r_hcnt  <= 4'd0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_grant <= 4'b0000;
          r_hcnt  <= 4'd0;
        end
      endcase
    end
  end

  always_comb begin
    case (r_sel)
      2'd0:    w_mux = p0;
      2'd1:    w_mux = p1;
      2'd2:    w_mux = p2;
      default: w_mux = p3;
    endcase
  end

  assign grant       = r_grant;
  assign sel         = r_sel;
  assign sout        = (r_state == ST_OWN) ? w_mux : 2'b00;
  assign sout_vld    = (r_state == ST_OWN);
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed bench for rr_mux_arbiter: one instance at HOLD_MAX=4, one at HOLD_MAX=1.
// Inputs change 1 time unit after a rising edge; outputs are checked there too.
module tb_rr_mux_arbiter;

  logic       clk = 1'b0;
  logic       rstn;
  logic [3:0] req;
  logic [3:0] req_b;
  logic [1:0] p0, p1, p2, p3;
  logic [3:0] grant, grant_b;
  logic [1:0] sel, sel_b, sout, sout_b;
  logic       sout_vld, sout_vld_b, dbg_state, dbg_state_b;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rr_mux_arbiter #(.HOLD_MAX(4)) u_dut (
    .clk(clk), .rstn(rstn), .req(req),
    .p0(p0), .p1(p1), .p2(p2), .p3(p3),
    .grant(grant), .sel(sel), .sout(sout), .sout_vld(sout_vld),
    .o_dbg_state(dbg_state)
  );

  rr_mux_arbiter #(.HOLD_MAX(1)) u_dut_h1 (
    .clk(clk), .rstn(rstn), .req(req_b),
    .p0(p0), .p1(p1), .p2(p2), .p3(p3),
    .grant(grant_b), .sel(sel_b), .sout(sout_b), .sout_vld(sout_vld_b),
    .o_dbg_state(dbg_state_b)
  );

  task automatic do_reset();
    @(posedge clk); #1;
    rstn  = 1'b0;
    req   = 4'b0000;
    req_b = 4'b0000;
    #2;
    rstn  = 1'b1;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0; req = 4'b0000; req_b = 4'b0000;
    p0 = 2'b00; p1 = 2'b01; p2 = 2'b10; p3 = 2'b11;
    step();
    n_cmp++; if (grant !== 4'b0000) begin n_err++; $display("FAIL reset_grant got=%b exp=0000", grant); end
    n_cmp++; if (sel !== 2'b00) begin n_err++; $display("FAIL reset_sel got=%b exp=00", sel); end
    n_cmp++; if (sout_vld !== 1'b0 || sout !== 2'b00) begin n_err++; $display("FAIL reset_sout got=%b/%b exp=0/00", sout_vld, sout); end
    n_cmp++; if (dbg_state !== 1'b0) begin n_err++; $display("FAIL reset_state got=%b exp=0", dbg_state); end
    rstn = 1'b1;
    req  = 4'b0100;
    step();
    n_cmp++; if (grant !== 4'b0100 || dbg_state !== 1'b1) begin n_err++; $display("FAIL first_edge_grant got=%b st=%b exp=0100 st=1", grant, dbg_state); end
    // Asynchronous abort while owning: no clock edge in between.
    rstn = 1'b0;
    #1;
    n_cmp++; if (grant !== 4'b0000) begin n_err++; $display("FAIL async_abort_grant got=%b exp=0000", grant); end
    n_cmp++; if (sout_vld !== 1'b0 || sout !== 2'b00) begin n_err++; $display("FAIL async_abort_sout got=%b/%b exp=0/00", sout_vld, sout); end
    n_cmp++; if (sel !== 2'b00) begin n_err++; $display("FAIL async_abort_sel got=%b exp=00", sel); end
    rstn = 1'b1;
    req  = 4'b1111;
    step();
    n_cmp++; if (grant !== 4'b0001) begin n_err++; $display("FAIL post_reset_prio got=%b exp=0001", grant); end
  endtask

  task automatic test_single();
    do_reset();
    p0  = 2'b10;
    req = 4'b0001;
    for (int c = 0; c < 10; c++) begin
      step();
      n_cmp++; if (grant !== 4'b0001 || sel !== 2'b00) begin n_err++; $display("FAIL single_grant c=%0d got=%b/%b exp=0001/00", c, grant, sel); end
      n_cmp++; if (sout !== 2'b10 || sout_vld !== 1'b1) begin n_err++; $display("FAIL single_sout c=%0d got=%b/%b exp=10/1", c, sout, sout_vld); end
    end
  endtask

  task automatic test_full_load();
    logic [3:0] exp_g [5];
    exp_g[0] = 4'b0001; exp_g[1] = 4'b0010; exp_g[2] = 4'b0100; exp_g[3] = 4'b1000; exp_g[4] = 4'b0001;
    do_reset();
    p0 = 2'b00; p1 = 2'b01; p2 = 2'b10; p3 = 2'b11;
    req = 4'b1111;
    for (int c = 0; c < 20; c++) begin
      step();
      n_cmp++; if (grant !== exp_g[c/4]) begin n_err++; $display("FAIL full_grant c=%0d got=%b exp=%b", c, grant, exp_g[c/4]); end
      n_cmp++; if (sel !== 2'((c/4) % 4)) begin n_err++; $display("FAIL full_sel c=%0d got=%0d exp=%0d", c, sel, (c/4) % 4); end
      n_cmp++; if (sout !== 2'((c/4) % 4) || sout_vld !== 1'b1) begin n_err++; $display("FAIL full_sout c=%0d got=%b/%b exp=%0d/1", c, sout, sout_vld, (c/4) % 4); end
    end
  endtask

  task automatic test_hold_stable();
    do_reset();
    req = 4'b0001;
    step();
    req = 4'b1111;
    for (int c = 0; c < 3; c++) begin
      step();
      n_cmp++; if (grant !== 4'b0001) begin n_err++; $display("FAIL hold_stable c=%0d got=%b exp=0001", c, grant); end
    end
    step();
    n_cmp++; if (grant !== 4'b0010) begin n_err++; $display("FAIL hold_handover got=%b exp=0010", grant); end
  endtask

  task automatic test_early_drop();
    do_reset();
    req = 4'b0101;
    step();
    step();
    n_cmp++; if (grant !== 4'b0001) begin n_err++; $display("FAIL drop_before got=%b exp=0001", grant); end
    req = 4'b0100;
    step();
    n_cmp++; if (grant !== 4'b0100 || sel !== 2'd2 || sout_vld !== 1'b1) begin n_err++; $display("FAIL drop_handover got=%b/%0d/%b exp=0100/2/1", grant, sel, sout_vld); end
    req = 4'b0101;
    for (int c = 0; c < 3; c++) begin
      step();
      n_cmp++; if (grant !== 4'b0100) begin n_err++; $display("FAIL drop_hold c=%0d got=%b exp=0100", c, grant); end
    end
    step();
    n_cmp++; if (grant !== 4'b0001) begin n_err++; $display("FAIL drop_rotate got=%b exp=0001", grant); end
  endtask

  task automatic test_idle_return();
    do_reset();
    req = 4'b0010;
    step();
    n_cmp++; if (grant !== 4'b0010 || sel !== 2'd1) begin n_err++; $display("FAIL idle_own got=%b/%0d exp=0010/1", grant, sel); end
    req = 4'b0000;
    for (int c = 0; c < 2; c++) begin
      step();
      n_cmp++; if (grant !== 4'b0000 || sout_vld !== 1'b0 || sout !== 2'b00) begin n_err++; $display("FAIL idle_release c=%0d got=%b/%b/%b exp=0000/0/00", c, grant, sout_vld, sout); end
      n_cmp++; if (sel !== 2'd1 || dbg_state !== 1'b0) begin n_err++; $display("FAIL idle_sel c=%0d got=%0d st=%b exp=1 st=0", c, sel, dbg_state); end
    end
    req = 4'b0011;
    step();
    n_cmp++; if (grant !== 4'b0001 || sel !== 2'd0) begin n_err++; $display("FAIL idle_wrap got=%b/%0d exp=0001/0", grant, sel); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    req_b = 4'b1010;
    for (int c = 0; c < 8; c++) begin
      step();
      n_cmp++; if (grant_b !== ((c % 2 == 0) ? 4'b0010 : 4'b1000)) begin n_err++; $display("FAIL rotate_h1 c=%0d got=%b exp=%b", c, grant_b, (c % 2 == 0) ? 4'b0010 : 4'b1000); end
      n_cmp++; if ($countones(grant_b) > 1 || sout_vld_b !== 1'b1) begin n_err++; $display("FAIL onehot_h1 c=%0d got=%b vld=%b exp=onehot/1", c, grant_b, sout_vld_b); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_full_load();
    test_hold_stable();
    test_early_drop();
    test_idle_return();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rr_mux_arbiter.md
RR_MUX_ARBITER -- requirements
Module: rr_mux_arbiter

Interface
REQ-001 The block SHALL have parameter HOLD_MAX, default 4, legal range 1..15: maximum consecutive cycles one requester keeps the grant.
REQ-002 Port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-003 Port rstn, input, 1, reset; asynchronous, active-low.
REQ-004 Port req, input, 4, request per requester; bit i belongs to requester i.
REQ-005 Ports p0, p1, p2, p3, input, 2 each, data of requesters 0..3.
REQ-006 Port grant, output, 4, registered one-hot grant; all zeros when no owner.
REQ-007 Port sel, output, 2, registered index of the current or last owner; drives the 4:1 select.
REQ-008 Port sout, output, 2, shared channel data.
REQ-009 Port sout_vld, output, 1, high while an owner holds the channel.

Function
REQ-010 The FSM SHALL have two states: IDLE (no owner) and OWN (grant non-zero).
REQ-011 The block SHALL hold a 2-bit priority pointer ptr (the last owner) and a 4-bit hold counter hcnt.
REQ-012 Arbitration SHALL search req starting at index (ptr+1) mod 4 and ascending with wrap; the first set bit wins.
REQ-013 In IDLE, when req is non-zero at a clock edge, at that edge: state goes to OWN, grant becomes one-hot of the winner, sel and ptr take the winner index, and hcnt is set to 1.
REQ-014 Grant latency SHALL be exactly one cycle from the first edge that samples the request.
REQ-015 In IDLE with req equal to 0, all state SHALL hold.
REQ-016 In OWN, the release condition SHALL be req[sel]==0 OR hcnt==HOLD_MAX, evaluated at each edge.
REQ-017 In OWN without release, grant and sel SHALL hold and hcnt SHALL increment by 1.
REQ-018 On release with req non-zero, the block SHALL re-arbitrate per REQ-012 at that same edge, with ptr equal to the releasing owner.
  - Back-to-back handover; no IDLE cycle.
  - hcnt is set to 1.
  - This path also applies when the releasing owner is the only requester: it is re-granted without a gap.
REQ-019 On release with req equal to 0, at that edge: state goes to IDLE, grant becomes 0, and sel and ptr keep the last owner.
REQ-020 A grant SHALL therefore last at most HOLD_MAX cycles; with HOLD_MAX=1, ownership rotates every cycle under full load.
REQ-021 sout SHALL be combinational: p[sel] when state is OWN, otherwise 2'b00.
REQ-022 sout_vld SHALL equal (state==OWN).
REQ-023 A requester that drops req is still shown as granted in the cycle in which the drop is first sampled; the grant changes at that edge.
REQ-024 Requests that change while a grant is held SHALL NOT affect the current owner until release.
REQ-025 grant SHALL never have more than one bit set.

Reset
REQ-026 When rstn is low, the block SHALL immediately force:
  - state IDLE;
  - grant 4'b0000;
  - sel 2'b00;
  - ptr 2'b11, so requester 0 has first priority;
  - hcnt 0;
  - sout 2'b00 and sout_vld 0.
REQ-027 Reset mid-grant SHALL abort ownership with no residual grant; arbitration after release of rstn SHALL restart as in REQ-026.
REQ-028 The first edge with rstn high SHALL be able to sample req and grant per REQ-013.

Verification
REQ-029 Reset: assert rstn=0 while in OWN -> grant=0000, sout_vld=0, sout=00 with no clock edge needed; after release, req=1111 -> grant=0001.
REQ-030 Single requester, HOLD_MAX=4, req=0001 held, p0=2'b10 -> grant=0001 continuously from one cycle after the first sampled edge, with no gap at the 4-cycle re-grant; sout=10 and sout_vld=1 throughout.
REQ-031 Full load, HOLD_MAX=4, req=1111 -> grant sequence 0001, 0010, 0100, 1000, 0001, each exactly 4 cycles; sel 0,1,2,3,0; sout follows p0..p3 (00,01,10,11).
REQ-032 Early drop: req=0101, owner 0, req0 drops after 2 grant cycles -> grant=0100 at the edge sampling the drop, hcnt restarts, and req2 owns for up to 4 cycles.
REQ-033 Idle return: sole owner 1 drops req -> grant=0000 and sout_vld=0 next edge with sel=01 held; later req=0011 -> grant=0010? No: the search starts at ptr+1=2 and wraps, so grant=0001.
REQ-034 Rotation fairness: HOLD_MAX=1, req=1010 -> grant alternates 0010, 1000 every cycle, never 0001 or 0100, and never more than one bit set.
